// File: rtl/pow_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin power scheduler.
// Holds the FSM encoding, default widths and the rotating-priority pick function.
package pow_rr_scheduler_pkg;

  localparam int unsigned DefNumReq = 4;
  localparam int unsigned DefWidth  = 18;
  localparam int unsigned DefExpW   = 3;
  localparam int unsigned MaxReq    = 8;
  localparam int unsigned IdxW      = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // First set request searching upward from last+1, wrapping at num_req.
  function automatic logic [IdxW-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                              input logic [IdxW-1:0]   last,
                                              input int unsigned       num_req);
    logic [IdxW-1:0] pick;
    logic [IdxW-1:0] cand;
    logic            found;
    pick  = last;
    cand  = last;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < num_req) begin
        cand = (cand == IdxW'(num_req - 1)) ? '0 : cand + 1'b1;
        if (!found && req[cand]) begin
          pick  = cand;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pow_rr_scheduler_iter.sv
// Sequential power datapath: one multiply per cycle, latched operands.
// last_step rises one cycle after the multiply loop has finished.
module pow_iter_unit
  import pow_rr_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned EXP_W = DefExpW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [EXP_W-1:0] exp,
  output logic             last_step,
  output logic [WIDTH-1:0] mul
);

  logic [WIDTH-1:0] r_n_q, r_n_d;
  logic [WIDTH-1:0] mul_q, mul_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             last_q, last_d;

  always_comb begin
    r_n_d    = r_n_q;
    mul_d    = mul_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    last_d   = 1'b0;
    if (start) begin
      r_n_d    = n;
      active_d = 1'b1;
      if (exp != '0) begin
        mul_d = n;
        cnt_d = exp - 1'b1;
      end else begin
        mul_d = WIDTH'(1);
        cnt_d = '0;
      end
    end else if (active_q) begin
      if (cnt_q != '0) begin
        mul_d = mul_q * r_n_q;
        cnt_d = cnt_q - 1'b1;
      end else begin
        // Product is final; flag it on the next cycle so the scheduler's latency is exp+1.
        active_d = 1'b0;
        last_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_n_q    <= '0;
      mul_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      r_n_q    <= r_n_d;
      mul_q    <= mul_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      last_q   <= last_d;
    end
  end

  assign last_step = last_q;
  assign mul       = mul_q;

endmodule

// File: rtl/pow_rr_scheduler.sv
// Round-robin scheduler sharing one iterative power unit between NUM_REQ requesters.
// Arbitrates in IDLE, runs the multiply loop in CALC, pulses done in DONE.
module pow_rr_scheduler
  import pow_rr_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned EXP_W   = DefExpW
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_n,
  input  logic [NUM_REQ*EXP_W-1:0] req_exp,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
  output logic                     busy
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [IdxW-1:0]    last_q, last_d;

  logic [MaxReq-1:0]  req_pad;
  logic [IdxW-1:0]    pick;
  logic [WIDTH-1:0]   sel_n;
  logic [EXP_W-1:0]   sel_exp;
  logic               start;
  logic               last_step;
  logic [WIDTH-1:0]   mul;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req;
  end

  assign pick = rr_pick(req_pad, last_q, NUM_REQ);

  always_comb begin
    sel_n   = '0;
    sel_exp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IdxW'(i)) begin
        sel_n   = req_n[i*WIDTH +: WIDTH];
        sel_exp = req_exp[i*EXP_W +: EXP_W];
      end
    end
  end

  pow_iter_unit #(
    .WIDTH (WIDTH),
    .EXP_W (EXP_W)
  ) u_iter (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .n         (sel_n),
    .exp       (sel_exp),
    .last_step (last_step),
    .mul       (mul)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      last_q   <= IdxW'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    result_d = result_q;
    last_d   = last_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            grant_d[i] = (pick == IdxW'(i));
          end
          last_d  = pick;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (last_step) begin
          done_d   = grant_q;
          result_d = mul;
          state_d  = StDone;
        end
      end
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q != StIdle);
    start = (state_q == StIdle) && (|req);
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_pow_rr_scheduler.sv
// Directed bench for pow_rr_scheduler: latency, results, rotation, operand latching, reset.
module tb_pow_rr_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 18;
  localparam int unsigned EXP_W   = 3;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_n;
  logic [NUM_REQ*EXP_W-1:0] req_exp;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [WIDTH-1:0]         result;
  logic                     busy;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  pow_rr_scheduler #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .EXP_W   (EXP_W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .req_n   (req_n),
    .req_exp (req_exp),
    .grant   (grant),
    .done    (done),
    .result  (result),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish before 200000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
  endtask

  function automatic logic [NUM_REQ-1:0] oh(input int idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic set_op(input int idx, input int n, input int e);
    req_n[idx*WIDTH +: WIDTH]   = WIDTH'(n);
    req_exp[idx*EXP_W +: EXP_W] = EXP_W'(e);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input int idx);
    int k;
    k = 0;
    while (grant == '0 && k < 40) begin
      step();
      k++;
    end
    check({tag, "_grant"}, 32'(grant), 32'(oh(idx)));
  endtask

  // Called in the cycle right after the granting edge.
  task automatic wait_done(input string tag, input int idx, input int res, input int lat);
    int k;
    k = 0;
    while (done == '0 && k < 40) begin
      step();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(lat));
    check({tag, "_done"}, 32'(done), 32'(oh(idx)));
    check({tag, "_result"}, 32'(result), 32'(res));
  endtask

  task automatic run_single(input string tag, input int idx, input int n, input int e,
                            input int res, input int lat);
    set_op(idx, n, e);
    req[idx] = 1'b1;
    step();
    check({tag, "_grant"}, 32'(grant), 32'(oh(idx)));
    wait_done(tag, idx, res, lat);
    req[idx] = 1'b0;
    step();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    req     = '0;
    req_n   = '0;
    req_exp = '0;
    step();
    step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    check("idle_noreq_busy", 32'(busy), 32'd0);

    // 3^5, cycle by cycle
    set_op(0, 3, 5);
    req[0] = 1'b1;
    step();
    check("t1_grant", 32'(grant), 32'b0001);
    check("t1_busy_e0", 32'(busy), 32'd1);
    check("t1_done_e0", 32'(done), 32'd0);
    repeat (5) step();
    check("t1_done_e5", 32'(done), 32'd0);
    check("t1_busy_e5", 32'(busy), 32'd1);
    step();
    check("t1_done_e6", 32'(done), 32'b0001);
    check("t1_result", 32'(result), 32'd243);
    check("t1_busy_e6", 32'(busy), 32'd1);
    req[0] = 1'b0;
    step();
    check("t1_done_e7", 32'(done), 32'd0);
    check("t1_grant_e7", 32'(grant), 32'd0);
    check("t1_busy_e7", 32'(busy), 32'd0);
    check("t1_result_hold", 32'(result), 32'd243);

    run_single("t2_20p5", 0, 20, 5, 54272, 6);
    run_single("t2_7p0", 0, 7, 0, 1, 2);
    run_single("t2_0p0", 0, 0, 0, 1, 2);

    // All four requesting; rotation 0,1,2,3,0
    pulse_reset();
    for (int i = 0; i < 4; i++) set_op(i, i + 2, 2);
    req = 4'hF;
    for (int j = 0; j < 5; j++) begin
      wait_grant($sformatf("t3_job%0d", j), j % 4);
      wait_done($sformatf("t3_job%0d", j), j % 4, (j % 4 + 2) * (j % 4 + 2), 3);
      if (j == 4) req = '0;
      step();
    end

    // req[1] arrives during job 0 and is served before req[2]
    pulse_reset();
    req = 4'b0101;
    wait_grant("t4_job0", 0);
    req[1] = 1'b1;
    wait_done("t4_job0", 0, 4, 3);
    step();
    wait_grant("t4_job1", 1);
    wait_done("t4_job1", 1, 9, 3);
    step();
    wait_grant("t4_job2", 2);
    wait_done("t4_job2", 2, 16, 3);
    req = '0;
    step();

    // Operands changed after grant must not affect the job
    set_op(3, 5, 7);
    req = 4'b1000;
    step();
    check("t5_grant", 32'(grant), 32'b1000);
    set_op(3, 9, 1);
    wait_done("t5", 3, 78125, 8);
    req = '0;
    step();

    // Reset mid-CALC abandons the job and rewinds the pointer
    set_op(0, 3, 5);
    set_op(1, 3, 1);
    req = 4'b0011;
    step();
    check("t6_grant", 32'(grant), 32'b0001);
    step();
    step();
    reset = 1'b1;
    step();
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    step();
    check("t6_regrant", 32'(grant), 32'b0001);
    wait_done("t6", 0, 243, 6);
    req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
